wb_arbiter: RTL and testbench

- Writeback arbiter that sits directly upstream of the register file and drives its single write port (wena/waddr/wdata).
- Merges two sources:
  - the in-order pipeline WB result (primary, never stalled);
  - results from long-latency units such as mul/div (secondary, valid/ready handshake, buffered in a small FIFO).
- Flags decode-stage reads that hit a still-pending buffered write, so the hazard unit can stall.

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_fifo.sv | 95 +++++++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback constants, used by the arbiter, the register file and the hazard unit.
package wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Which source drives the register-file write port in the next cycle.
    typedef enum logic [1:0] {
        SEL_IDLE        = 2'd0,
        SEL_PRIMARY     = 2'd1,
        SEL_FIFO_LIVE   = 2'd2,
        SEL_FIFO_KILLED = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of secondary writebacks with per-entry live bits,
// kill-by-address, and two address-match queries over live entries.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [ADDR_W-1:0]        push_addr_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    input  logic                     kill_i,
    input  logic [ADDR_W-1:0]        kill_addr_i,
    input  logic [ADDR_W-1:0]        q1_addr_i,
    input  logic [ADDR_W-1:0]        q2_addr_i,
    output logic                     hit1_o,
    output logic                     hit2_o,
    output logic                     head_live_o,
    output logic [ADDR_W-1:0]        head_addr_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Live bits stay zero on empty slots, so the hit queries need no occupancy mask.
    always_comb begin
        live_d = live_q;
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == kill_addr_i) live_d[i] = 1'b0;
            end
        end
        if (pop_i) live_d[rd_ptr_q] = 1'b0;
        if (push_i) live_d[wr_ptr_q] = !(kill_i && (push_addr_i == kill_addr_i));
    end

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        hit1_o = 1'b0;
        hit2_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == q1_addr_i)) hit1_o = 1'b1;
            if (live_q[i] && (addr_q[i] == q2_addr_i)) hit2_o = 1'b1;
        end
        if (q1_addr_i == ADDR_W'(REG_ZERO)) hit1_o = 1'b0;
        if (q2_addr_i == ADDR_W'(REG_ZERO)) hit2_o = 1'b0;
    end

    assign head_live_o = live_q[rd_ptr_q];
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the in-order primary result always wins,
// long-latency secondary results drain from a FIFO when the primary is idle.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p_valid,
    input  logic [ADDR_W-1:0]      p_waddr,
    input  logic [DATA_W-1:0]      p_wdata,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [ADDR_W-1:0]      s_waddr,
    input  logic [DATA_W-1:0]      s_wdata,
    input  logic [ADDR_W-1:0]      raddr1,
    input  logic [ADDR_W-1:0]      raddr2,
    output logic                   pend_hit1,
    output logic                   pend_hit2,
    output logic                   wena,
    output logic [ADDR_W-1:0]      waddr,
    output logic [DATA_W-1:0]      wdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              p_write;
    logic              s_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              head_live;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  fifo_count;
    wb_sel_e           sel;

    logic              wena_q, wena_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Secondary handshake: a result transfers on any rising edge where
    // s_valid && s_ready; s_ready looks only at the registered occupancy,
    // so a pop in the same cycle never frees a slot early. Results to $0
    // complete the handshake but are discarded.
    assign s_ready  = (fifo_count < CNT_W'(DEPTH)) && !rst;
    assign p_write  = p_valid && (p_waddr != ADDR_W'(REG_ZERO));
    assign s_push   = s_valid && s_ready && (s_waddr != ADDR_W'(REG_ZERO));
    assign fifo_pop = !rst && !p_write && !fifo_empty;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (s_push),
        .push_addr_i (s_waddr),
        .push_data_i (s_wdata),
        .pop_i       (fifo_pop),
        .kill_i      (p_write),
        .kill_addr_i (p_waddr),
        .q1_addr_i   (raddr1),
        .q2_addr_i   (raddr2),
        .hit1_o      (pend_hit1),
        .hit2_o      (pend_hit2),
        .head_live_o (head_live),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        sel     = SEL_IDLE;
        wena_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (p_write) begin
            sel = SEL_PRIMARY;
        end else if (!fifo_empty) begin
            sel = head_live ? SEL_FIFO_LIVE : SEL_FIFO_KILLED;
        end
        case (sel)
            SEL_PRIMARY: begin
                wena_d  = 1'b1;
                waddr_d = p_waddr;
                wdata_d = p_wdata;
            end
            SEL_FIFO_LIVE: begin
                wena_d  = 1'b1;
                waddr_d = head_addr;
                wdata_d = head_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wena_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wena_q  <= wena_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wena  = wena_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign count = fifo_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based model.
module tb_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int EW     = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              p_valid;
    logic [ADDR_W-1:0] p_waddr;
    logic [DATA_W-1:0] p_wdata;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_waddr;
    logic [DATA_W-1:0] s_wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic              wena;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [$clog2(DEPTH):0] count;

    wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_waddr   (p_waddr),
        .p_wdata   (p_wdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_waddr   (s_waddr),
        .s_wdata   (s_wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2),
        .wena      (wena),
        .waddr     (waddr),
        .wdata     (wdata),
        .count     (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: pending secondary results in program order
    typedef struct {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [EW-1:0]     exp_q[$];

    // driver: one call = one clock cycle of stimulus plus its model update
    task automatic step(input logic r, input logic pv, input logic [ADDR_W-1:0] pa,
                        input logic [DATA_W-1:0] pd, input logic sv,
                        input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                        input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        logic e_rdy, e_h1, e_h2, e_wena, p_wr;
        ent_t h;
        @(negedge clk);
        rst = r; p_valid = pv; p_waddr = pa; p_wdata = pd;
        s_valid = sv; s_waddr = sa; s_wdata = sd; raddr1 = r1; raddr2 = r2;
        #1;
        e_rdy = !r && (mq.size() < DEPTH);
        e_h1 = 1'b0;
        e_h2 = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].addr == r1 && r1 != 0) e_h1 = 1'b1;
            if (mq[i].live && mq[i].addr == r2 && r2 != 0) e_h2 = 1'b1;
        end
        chk("s_ready", 64'(s_ready), 64'(e_rdy));
        chk("count", 64'(count), 64'(mq.size()));
        chk("pend_hit1", 64'(pend_hit1), 64'(e_h1));
        chk("pend_hit2", 64'(pend_hit2), 64'(e_h2));
        e_wena = 1'b0;
        if (r) begin
            mq.delete();
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            p_wr = pv && (pa != 0);
            if (p_wr) begin
                e_wena = 1'b1; m_waddr = pa; m_wdata = pd;
                foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.live) begin
                    e_wena = 1'b1; m_waddr = h.addr; m_wdata = h.data;
                end
            end
            if (sv && e_rdy && sa != 0) begin
                h.live = !(p_wr && sa == pa);
                h.addr = sa;
                h.data = sd;
                mq.push_back(h);
            end
        end
        exp_q.push_back({e_wena, m_waddr, m_wdata});
    endtask

    task automatic idle(input int n, input logic [ADDR_W-1:0] r1);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r1, '0);
    endtask

    // monitor: each cycle's registered write port against the model's record
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wena", 64'(wena), 64'(e[EW-1]));
            chk("waddr", 64'(waddr), 64'(e[DATA_W +: ADDR_W]));
            chk("wdata", 64'(wdata), 64'(e[DATA_W-1:0]));
        end
    end

    initial begin
        rst = 1'b1; p_valid = 1'b0; p_waddr = '0; p_wdata = '0;
        s_valid = 1'b0; s_waddr = '0; s_wdata = '0; raddr1 = '0; raddr2 = '0;

        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        idle(1, '0);

        // primary-only write
        step(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, '0, '0, '0, '0);
        idle(2, '0);

        // primary priority over a queued secondary, with hazard query on $7
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd7);
        step(1'b0, 1'b1, 5'd1, 32'h101, 1'b0, '0, '0, 5'd7, '0);
        step(1'b0, 1'b1, 5'd2, 32'h102, 1'b0, '0, '0, 5'd7, '0);
        step(1'b0, 1'b1, 5'd4, 32'h104, 1'b0, '0, '0, 5'd7, '0);
        idle(2, 5'd7);

        // fill the FIFO behind a busy primary, then offer a fifth result
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'(10 + i), 32'(200 + i), 1'b1, 5'(20 + i), 32'(300 + i), 5'd20, 5'd23);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd24, 32'h324, 5'd24, 5'd21);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd24, 32'h324, 5'd24, 5'd21);
        idle(6, 5'd24);

        // WAW kill: younger primary to $9 supersedes the queued secondary
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h22, 5'd9, '0);
        step(1'b0, 1'b1, 5'd9, 32'h33, 1'b0, '0, '0, 5'd9, '0);
        idle(3, 5'd9);

        // same-cycle kill of an entering secondary
        step(1'b0, 1'b1, 5'd12, 32'h44, 1'b1, 5'd12, 32'h55, 5'd12, '0);
        idle(2, 5'd12);

        // zero register on both sources
        step(1'b0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE, 5'd0, 5'd0);
        idle(2, 5'd0);

        // reset with three entries pending
        step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h505, 5'd5, 5'd6);
        step(1'b0, 1'b1, 5'd1, 32'h2, 1'b1, 5'd6, 32'h606, 5'd5, 5'd6);
        step(1'b0, 1'b1, 5'd1, 32'h3, 1'b1, 5'd8, 32'h808, 5'd8, 5'd6);
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd11, 32'hB0B, 5'd5, 5'd8);
        idle(4, 5'd5);

        // randomized traffic over a small register window to force collisions
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2, '0);

        @(negedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
